// File: rtl/rs_slot_allocator.sv
// rtl/rs_slot_allocator.sv - reservation-station slot allocator built on a circular free list
// All-or-nothing multi-lane allocation from head, duplicate-checked multi-lane release at tail.
module rs_slot_allocator #(
    parameter  int NUM_ENTRIES = 8,
    parameter  int ALLOC_PORTS = 2,
    parameter  int FREE_PORTS  = 2,
    localparam int IW          = $clog2(NUM_ENTRIES),
    localparam int CW          = IW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [ALLOC_PORTS-1:0]      alloc_req,
    output logic [ALLOC_PORTS*IW-1:0]   alloc_slot,
    output logic                        alloc_stall,
    input  logic [FREE_PORTS-1:0]       free_valid,
    input  logic [FREE_PORTS*IW-1:0]    free_slot,
    output logic [CW-1:0]               free_count,
    output logic [NUM_ENTRIES-1:0]      busy_map,
    output logic                        err_double_free
);

    logic [IW-1:0]          list_q [NUM_ENTRIES];
    logic [IW-1:0]          list_d [NUM_ENTRIES];
    logic [IW-1:0]          head_q, head_d;
    logic [IW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          free_count_q, free_count_d;
    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic                   err_q, err_d;

    logic [CW-1:0]          n_req;
    logic [CW-1:0]          n_granted;
    logic [CW-1:0]          n_acc;
    logic                   stall;
    logic [IW-1:0]          rank;
    logic [IW-1:0]          rd_idx;
    logic [IW-1:0]          wr_idx;
    logic [IW-1:0]          fslot;
    logic                   dup;
    logic [NUM_ENTRIES-1:0] busy_set;
    logic [NUM_ENTRIES-1:0] busy_clr;

    always_comb begin
        n_req = '0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            n_req = n_req + CW'(alloc_req[k]);
        end
        stall     = (n_req > free_count_q);
        n_granted = stall ? '0 : n_req;

        // Lanes are packed: lane k takes the r_k-th free entry after head.
        alloc_slot = '0;
        busy_set   = '0;
        rank       = '0;
        rd_idx     = '0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            if (alloc_req[k]) begin
                rd_idx = head_q + rank;
                if (!stall) begin
                    alloc_slot[k*IW +: IW] = list_q[rd_idx];
                    busy_set[list_q[rd_idx]] = 1'b1;
                end
                rank = rank + IW'(1);
            end
        end

        list_d   = list_q;
        busy_clr = '0;
        n_acc    = '0;
        err_d    = 1'b0;
        wr_idx   = '0;
        fslot    = '0;
        dup      = 1'b0;
        for (int j = 0; j < FREE_PORTS; j++) begin
            fslot = free_slot[j*IW +: IW];
            dup   = 1'b0;
            for (int jj = 0; jj < j; jj++) begin
                if (free_valid[jj] && (free_slot[jj*IW +: IW] == fslot)) begin
                    dup = 1'b1;
                end
            end
            if (free_valid[j]) begin
                if (busy_q[fslot] && !dup) begin
                    wr_idx         = tail_q + n_acc[IW-1:0];
                    list_d[wr_idx] = fslot;
                    busy_clr[fslot] = 1'b1;
                    n_acc          = n_acc + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // Granted ids are free and accepted ids are busy, so set/clear never collide.
        head_d       = head_q + n_granted[IW-1:0];
        tail_d       = tail_q + n_acc[IW-1:0];
        free_count_d = free_count_q - n_granted + n_acc;
        busy_d       = (busy_q | busy_set) & ~busy_clr;

        if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                list_d[i] = IW'(i);
            end
            head_d       = '0;
            tail_d       = '0;
            free_count_d = CW'(NUM_ENTRIES);
            busy_d       = '0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                list_q[i] <= IW'(i);
            end
            head_q       <= '0;
            tail_q       <= '0;
            free_count_q <= CW'(NUM_ENTRIES);
            busy_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            list_q       <= list_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign alloc_stall     = stall;
    assign free_count      = free_count_q;
    assign busy_map        = busy_q;
    assign err_double_free = err_q;

endmodule

// File: tb/tb_rs_slot_allocator.sv
// tb/tb_rs_slot_allocator.sv - randomized and directed bench for rs_slot_allocator
// Reference keeps the free ids in a FIFO queue and the busy set as a bit vector.
module tb_rs_slot_allocator;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] alloc_req;
    logic [5:0] alloc_slot;
    logic       alloc_stall;
    logic [1:0] free_valid;
    logic [5:0] free_slot;
    logic [3:0] free_count;
    logic [7:0] busy_map;
    logic       err_double_free;

    int checks = 0;
    int errors = 0;

    int       fq[$];
    bit [7:0] mbusy;
    bit       merr;

    rs_slot_allocator #(.NUM_ENTRIES(8), .ALLOC_PORTS(2), .FREE_PORTS(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .alloc_req       (alloc_req),
        .alloc_slot      (alloc_slot),
        .alloc_stall     (alloc_stall),
        .free_valid      (free_valid),
        .free_slot       (free_slot),
        .free_count      (free_count),
        .busy_map        (busy_map),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < 8; i++) fq.push_back(i);
        mbusy = '0;
        merr  = 1'b0;
    endtask

    // Drive one cycle at the falling edge, check everything, then advance the model.
    task automatic cycle(input logic fl, input logic [1:0] req, input logic [1:0] fv,
                         input logic [2:0] fs0, input logic [2:0] fs1);
        int  n;
        int  r;
        int  expv;
        bit  stall;
        bit  acc0;
        bit  acc1;
        bit  rej;
        @(negedge clk);
        flush      = fl;
        alloc_req  = req;
        free_valid = fv;
        free_slot  = {fs1, fs0};
        #1;
        n     = int'(req[0]) + int'(req[1]);
        stall = (n > fq.size());
        chk("free_count", 32'(free_count), 32'(fq.size()));
        chk("busy_map", 32'(busy_map), 32'(mbusy));
        chk("err_double_free", 32'(err_double_free), 32'(merr));
        chk("conservation", 32'(free_count) + 32'($countones(busy_map)), 32'd8);
        chk("alloc_stall", 32'(alloc_stall), 32'(stall));
        r = 0;
        for (int k = 0; k < 2; k++) begin
            expv = (req[k] && !stall) ? fq[r] : 0;
            chk($sformatf("alloc_slot_lane%0d", k), 32'(alloc_slot[k*3 +: 3]), 32'(expv));
            if (req[k]) r++;
        end
        if (req == 2'b11 && !stall)
            chk("unique_ids", 32'(alloc_slot[2:0] != alloc_slot[5:3]), 32'd1);

        if (fl) begin
            model_reset();
        end else begin
            acc0 = fv[0] && mbusy[fs0];
            acc1 = fv[1] && mbusy[fs1] && !(fv[0] && fs0 == fs1);
            rej  = (fv[0] && !acc0) || (fv[1] && !acc1);
            if (!stall) begin
                for (int k = 0; k < n; k++) mbusy[fq.pop_front()] = 1'b1;
            end
            if (acc0) begin fq.push_back(int'(fs0)); mbusy[fs0] = 1'b0; end
            if (acc1) begin fq.push_back(int'(fs1)); mbusy[fs1] = 1'b0; end
            merr = rej;
        end
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        alloc_req  = '0;
        free_valid = '0;
        free_slot  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_free_count", 32'(free_count), 32'd8);
        chk("reset_busy_map", 32'(busy_map), 32'd0);
        chk("reset_err", 32'(err_double_free), 32'd0);
        chk("reset_alloc_slot", 32'(alloc_slot), 32'd0);

        // Two lanes from reset get ids 0 and 1.
        cycle(1'b0, 2'b11, 2'b00, 3'd0, 3'd0);
        @(posedge clk); #1;
        chk("dual_grant_busy", 32'(busy_map), 32'h03);
        chk("dual_grant_count", 32'(free_count), 32'd6);

        // Only lane 1 requests: it is packed onto the head id 0.
        cycle(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 2'b10, 2'b00, 3'd0, 3'd0);
        @(posedge clk); #1;
        chk("packing_busy", 32'(busy_map), 32'h01);

        // Exhaust, stall with same-cycle release, then regrant the released id.
        cycle(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);
        repeat (4) cycle(1'b0, 2'b11, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 2'b01, 2'b01, 3'd3, 3'd0);
        cycle(1'b0, 2'b01, 2'b00, 3'd0, 3'd0);

        // Illegal releases: already-free id, then same id on both lanes.
        cycle(1'b0, 2'b00, 2'b01, 3'd5, 3'd0);
        cycle(1'b0, 2'b00, 2'b01, 3'd5, 3'd0);
        cycle(1'b0, 2'b00, 2'b11, 3'd2, 3'd2);
        cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
        cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);

        // Flush beats simultaneous alloc and free.
        cycle(1'b1, 2'b11, 2'b01, 3'd1, 3'd0);
        cycle(1'b0, 2'b11, 2'b00, 3'd0, 3'd0);

        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 31) == 0),
                  2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end
        cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_slot_allocator.md
RS_SLOT_ALLOCATOR -- requirements
Module: rs_slot_allocator

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, meaning reservation-station depth; power of two, 4..64.
REQ-002 SHALL have parameter ALLOC_PORTS, default 2, meaning allocation lanes per cycle; range 1..4.
REQ-003 SHALL have parameter FREE_PORTS, default 2, meaning release lanes per cycle; range 1..4.
REQ-004 SHALL have derived width IW = $clog2(NUM_ENTRIES) for slot ids and CW = IW+1 for counts.
REQ-005 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have flush  input  1  discard all allocations and restore the full free list.
REQ-008 SHALL have alloc_req  input  ALLOC_PORTS  per-lane slot request; any bit pattern is legal.
REQ-009 SHALL have alloc_slot  output  ALLOC_PORTS*IW  granted slot id per lane; lane k in bits [k*IW +: IW].
REQ-010 SHALL have alloc_stall  output  1  request cannot be fully satisfied this cycle.
REQ-011 SHALL have free_valid  input  FREE_PORTS  per-lane release strobe.
REQ-012 SHALL have free_slot  input  FREE_PORTS*IW  slot id being released per lane.
REQ-013 SHALL have free_count  output  CW  registered number of free slots.
REQ-014 SHALL have busy_map  output  NUM_ENTRIES  registered bitmap; bit i set = slot i allocated.
REQ-015 SHALL have err_double_free  output  1  one-cycle pulse flagging an illegal release.

Function
REQ-016 SHALL hold free slot ids in a circular list of NUM_ENTRIES entries with head (next to allocate), tail (next write position) and free_count.
REQ-017 SHALL compute n_req = popcount(alloc_req) combinationally; alloc_stall = (n_req > free_count).
REQ-018 SHALL be all-or-nothing: when alloc_stall=1, no lane allocates and head, free_count and busy_map are unchanged by allocation.
REQ-019 SHALL, when not stalled, drive requesting lane k with list[head + r_k], where r_k = number of set alloc_req bits below k; lanes are packed with no gaps.
REQ-020 SHALL drive alloc_slot lanes with alloc_req=0, or any lane while stalled, to 0; never X.
REQ-021 SHALL, on a granted edge, advance head by n_req modulo NUM_ENTRIES and set busy_map for each granted id.
REQ-022 SHALL accept free lane j only if busy_map[free_slot_j]=1 and no lower lane j' < j releases the same id in that cycle.
REQ-023 SHALL write accepted releases at tail, tail+1, ... in ascending lane order, advance tail by the accepted count modulo NUM_ENTRIES, and clear their busy_map bits.
REQ-024 SHALL raise err_double_free for exactly the cycle after any rejected release; rejected lanes change no state.
REQ-025 SHALL NOT let releases in a cycle satisfy allocations in that same cycle; free_count and list contents used for allocation are the registered values.
REQ-026 SHALL update free_count = free_count - n_granted + n_accepted in one step when allocation and release occur together.
REQ-027 SHALL guarantee free_count never exceeds NUM_ENTRIES or underflows; this follows from REQ-018 and REQ-022.
REQ-028 SHALL give flush priority over same-cycle alloc and free: list[i]=i, head=0, tail=0, free_count=NUM_ENTRIES, busy_map=0, err_double_free=0 on the next edge.
REQ-029 SHALL treat tail == head with free_count = NUM_ENTRIES as full-free and with free_count = 0 as empty; the count alone disambiguates.

Reset
REQ-030 SHALL, on rst=1 at an edge, take the flush state of REQ-028; rst takes priority over flush.
REQ-031 SHALL, after reset, drive alloc_slot=0, alloc_stall=(n_req>NUM_ENTRIES), free_count=NUM_ENTRIES, busy_map=0 and err_double_free=0.

Verification
REQ-032 SHALL pass: reset, then alloc_req=2'b11 for 1 cycle -> alloc_slot lanes 0/1 = 0/1, next free_count=6, busy_map=8'h03.
REQ-033 SHALL pass: from reset, alloc_req=2'b10 -> lane1=0, lane0=0 (idle), next busy_map=8'h01 (packing check).
REQ-034 SHALL pass: allocate all 8, then alloc_req=2'b01 -> alloc_stall=1, state unchanged; same-cycle free of slot 3 -> stall still 1 that cycle, next cycle lane0 grants 3.
REQ-035 SHALL pass: free slot 5 while it is free, or both free lanes = slot 2 while busy -> err_double_free pulses 1 cycle; second lane ignored; free_count rises by 0 or 1 accordingly.
REQ-036 SHALL pass: 20 cycles of random 2-lane alloc/free with head/tail wrap -> ids always unique, free_count + popcount(busy_map) = 8 every cycle.
REQ-037 SHALL pass: flush asserted with simultaneous alloc_req=2'b11 and a free -> next cycle free_count=8, busy_map=0, next grant lanes = 0/1.
